// File: rtl/seq_line_decoder.sv
// Registered N-to-2^N line decoder with valid/ready intake and a fixed HOLD-cycle output pulse.
// Define SEQ_DEC_LINE0_EN to let code 0 drive out_line[0]; otherwise line 0 is tied low.
module seq_line_decoder #(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned HOLD  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [(1<<SEL_W)-1:0]   out_line,
  output logic                    out_valid,
  output logic                    out_last
);

  localparam int unsigned LINE_W = 1 << SEL_W;
  localparam int unsigned CNT_W  = $clog2(HOLD + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                accept;
  logic [LINE_W-1:0]   decoded;

  // Ready depends only on state and count so it never loops back through in_valid.
  assign in_ready = (state_q == IDLE) || (cnt_q == CNT_W'(1));
  assign accept   = in_valid && in_ready;

  always_comb begin
    decoded = LINE_W'(1) << in_sel;
`ifdef SEQ_DEC_LINE0_EN
`else
    decoded[0] = 1'b0;
`endif
  end

  // Next-state: a new accept always wins, so the final window cycle can reload without a gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    valid_d = valid_q;
    if (accept) begin
      state_d = DRIVE;
      cnt_d   = CNT_W'(HOLD);
      line_d  = decoded;
      valid_d = 1'b1;
    end else if (state_q == DRIVE) begin
      if (cnt_q == CNT_W'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
        line_d  = '0;
        valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
    last_d = (state_d == DRIVE) && (cnt_d == CNT_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_line  = line_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_seq_line_decoder.sv
// Bench for seq_line_decoder: two instances (SEL_W=3/HOLD=4 and SEL_W=4/HOLD=1) checked against
// a per-cycle output schedule model, with directed scenarios followed by random traffic.
module tb_seq_line_decoder;

  localparam int unsigned SW_A = 3;
  localparam int unsigned HD_A = 4;
  localparam int unsigned SW_B = 4;
  localparam int unsigned HD_B = 1;

  typedef struct packed {
    logic [63:0] line;
    logic        last;
  } slot_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic                  va = 1'b0, vb = 1'b0;
  logic [SW_A-1:0]       sa = '0;
  logic [SW_B-1:0]       sb = '0;
  logic                  rdy_a, rdy_b;
  logic [(1<<SW_A)-1:0]  line_a;
  logic [(1<<SW_B)-1:0]  line_b;
  logic                  oval_a, oval_b, olast_a, olast_b;

  int nchecks = 0;
  int nfail   = 0;
  slot_t qa[$];
  slot_t qb[$];
  logic acc_a, acc_b;

  seq_line_decoder #(.SEL_W(SW_A), .HOLD(HD_A)) u_a (
    .clk(clk), .rst(rst), .in_valid(va), .in_ready(rdy_a), .in_sel(sa),
    .out_line(line_a), .out_valid(oval_a), .out_last(olast_a)
  );

  seq_line_decoder #(.SEL_W(SW_B), .HOLD(HD_B)) u_b (
    .clk(clk), .rst(rst), .in_valid(vb), .in_ready(rdy_b), .in_sel(sb),
    .out_line(line_b), .out_valid(oval_b), .out_last(olast_b)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] exp_line(input int s);
    logic [63:0] one;
    one = 64'd1;
`ifdef SEQ_DEC_LINE0_EN
    return one << s;
`else
    return (s == 0) ? 64'd0 : (one << s);
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nchecks++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs();
    slot_t ea, eb;
    ea = (qa.size() > 0) ? qa[0] : '0;
    eb = (qb.size() > 0) ? qb[0] : '0;
    chk("a_line",  64'(line_a),  ea.line);
    chk("a_valid", 64'(oval_a),  64'(qa.size() > 0));
    chk("a_last",  64'(olast_a), 64'(ea.last));
    chk("b_line",  64'(line_b),  eb.line);
    chk("b_valid", 64'(oval_b),  64'(qb.size() > 0));
    chk("b_last",  64'(olast_b), 64'(eb.last));
  endtask

  // One clock: check ready with current inputs, advance both models on the edge, check outputs.
  task automatic cycle();
    logic era, erb;
    era = (qa.size() <= 1);
    erb = (qb.size() <= 1);
    chk("a_ready", 64'(rdy_a), 64'(era));
    chk("b_ready", 64'(rdy_b), 64'(erb));
    acc_a = va && era;
    acc_b = vb && erb;
    @(posedge clk);
    if (qa.size() > 0) void'(qa.pop_front());
    if (qb.size() > 0) void'(qb.pop_front());
    if (acc_a) for (int i = 0; i < int'(HD_A); i++) qa.push_back('{line: exp_line(int'(sa)), last: (i == int'(HD_A) - 1)});
    if (acc_b) for (int i = 0; i < int'(HD_B); i++) qb.push_back('{line: exp_line(int'(sb)), last: (i == int'(HD_B) - 1)});
    @(negedge clk);
    chk_outputs();
  endtask

  // Mid-cycle reset pulse that never spans a clock edge: clearing must be purely asynchronous.
  task automatic pulse_rst();
    #1 rst = 1'b1;
    #1;
    qa.delete();
    qb.delete();
    chk("rst_a_line",  64'(line_a),  64'd0);
    chk("rst_a_valid", 64'(oval_a),  64'd0);
    chk("rst_a_last",  64'(olast_a), 64'd0);
    chk("rst_a_ready", 64'(rdy_a),   64'd1);
    chk("rst_b_line",  64'(line_b),  64'd0);
    chk("rst_b_valid", 64'(oval_b),  64'd0);
    chk("rst_b_last",  64'(olast_b), 64'd0);
    chk("rst_b_ready", 64'(rdy_b),   64'd1);
    #1 rst = 1'b0;
  endtask

  task automatic idle_a(input int n);
    va = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    acc_a = 1'b0;
    acc_b = 1'b0;
    #2;
    chk("init_a_line",  64'(line_a), 64'd0);
    chk("init_a_valid", 64'(oval_a), 64'd0);
    chk("init_b_last",  64'(olast_b), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_outputs();

    // Single code 5: 0x20 for four cycles, ready low in the first three.
    va = 1'b1; sa = 3'd5;
    cycle();
    va = 1'b0;
    chk("dir_line5", 64'(line_a), 64'h20);
    idle_a(4);

    // Back-to-back: 6 held until accepted in the last cycle of 3's window.
    va = 1'b1; sa = 3'd3;
    cycle();
    sa = 3'd6;
    for (int i = 0; i < 4; i++) cycle();
    chk("b2b_line6", 64'(line_a), 64'h40);
    idle_a(4);

    // Stall: code 2 presented in cycle 2 of a window waits for the count-1 cycle.
    va = 1'b1; sa = 3'd7;
    cycle();
    va = 1'b0;
    cycle();
    va = 1'b1; sa = 3'd2;
    for (int i = 0; i < 3; i++) cycle();
    chk("stall_line2", 64'(line_a), 64'h04);
    idle_a(4);

    // Code 0 window.
    va = 1'b1; sa = 3'd0;
    cycle();
    idle_a(4);

    // HOLD=1 stream on the second instance, reset during the 0x0004 cycle.
    vb = 1'b1; sb = 4'd1;
    cycle();
    chk("s_line1", 64'(line_b), 64'h0002);
    sb = 4'd2;
    cycle();
    chk("s_line2", 64'(line_b), 64'h0004);
    pulse_rst();
    sb = 4'd15;
    cycle();
    chk("s_line15", 64'(line_b), 64'h8000);
    chk("s_last",   64'(olast_b), 64'd1);
    vb = 1'b0;
    cycle();

    // Random traffic; a presented code is held until accepted.
    acc_a = 1'b0;
    acc_b = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!(va && !acc_a)) begin
        va = 1'($urandom_range(0, 1));
        sa = SW_A'($urandom_range(0, (1 << SW_A) - 1));
      end
      if (!(vb && !acc_b)) begin
        vb = 1'($urandom_range(0, 1));
        sb = SW_B'($urandom_range(0, (1 << SW_B) - 1));
      end
      cycle();
      if ($urandom_range(0, 63) == 0) begin
        pulse_rst();
        acc_a = 1'b0;
        acc_b = 1'b0;
        va = 1'b0;
        vb = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule

// File: doc/seq_line_decoder.md
# seq_line_decoder

Registered, parametrised N-to-2^N line decoder with a valid/ready input handshake and a programmable output hold time. The block accepts a SEL_W-bit code, drives the matching one-hot line for exactly HOLD clock cycles, then releases it. It sits between control logic that issues select codes and downstream strobe consumers that need a clean, glitch-free, fixed-width pulse. It supersedes the purely combinational 3-to-8 decoder: width is generalised, outputs are registered, and pulse duration is controlled.

## Interface
- SEL_W, 3, width of the select code; output width is 2^SEL_W (legal 1..6)
- HOLD, 4, number of cycles each decoded line stays asserted (legal 1..255)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_sel is valid this cycle
- in_ready  output  1  block can accept a code this cycle
- in_sel  input  SEL_W  code to decode
- out_line  output  2^SEL_W  registered one-hot (or all-zero) line vector
- out_valid  output  1  out_line is being driven for an accepted code
- out_last  output  1  high in the final cycle of a hold window

## Operation
- One clock domain, clk; reset is asynchronous and active-high on rst.
- States: IDLE, DRIVE. Hold counter cnt, width clog2(HOLD+1).
- Reset values: state=IDLE, cnt=0, out_line=0, out_valid=0, out_last=0; in_ready=1 after reset deasserts.
- Accept = in_valid & in_ready, sampled on the rising clk edge.
- IDLE: in_ready=1. On accept -> DRIVE, out_line <= decode(in_sel), out_valid <= 1, cnt <= HOLD.
- DRIVE: out_line is held constant and in_sel is ignored. cnt decrements each cycle. out_last = (cnt==1).
- DRIVE with cnt==1: in_ready=1 (back-to-back allowed).
  - Accept in that cycle -> stay in DRIVE, load new line, cnt <= HOLD; no gap cycle.
  - No accept -> IDLE, out_line <= 0, out_valid <= 0.
- DRIVE with cnt>1: in_ready=0.
- decode(s): bit s set, all others 0, subject to Configuration for s==0.
- in_valid held high with in_ready low: the code is not consumed; the source must hold it stable until accepted.
- rst asserted mid-window: all outputs clear immediately (asynchronous) and the in-progress pulse is abandoned; operation resumes from IDLE on the first edge after release.

## Timing
- Latency: code accepted at edge k -> out_line/out_valid high from edge k (visible in cycle k+1) through cycle k+HOLD.
- HOLD=1: out_last is high in every drive cycle, and in_ready stays 1 continuously; one code per cycle sustained.
- Throughput: one code per HOLD cycles, back-to-back.
- All outputs are registered except in_ready, which is a combinational function of state and cnt only, never of in_valid.

## Configuration
- SEQ_DEC_LINE0_EN defined: code 0 drives out_line[0]=1, giving a full one-hot 2^SEL_W decode.
- SEQ_DEC_LINE0_EN undefined: out_line[0] is tied to 0. Code 0 is still accepted and runs a full HOLD window with out_valid=1 and out_last behaving normally, but out_line is all-zero during that window. This matches the legacy 1..7 line set.

## Test plan
- Reset: assert rst mid-simulation -> out_line=0, out_valid=0, out_last=0, in_ready=1 immediately, with no clock edge needed.
- SEL_W=3, HOLD=4: send in_sel=5 -> out_line=8'b0010_0000 for 4 cycles; out_last in the 4th cycle; in_ready low in the first 3 drive cycles.
- Back-to-back, HOLD=4: send 3 then 6 with in_valid held -> 6 accepted in the out_last cycle of 3; out_line changes 0x08->0x40 with no zero cycle.
- Stall: assert in_valid with in_sel=2 during cycle 2 of a window -> not accepted until the cnt==1 cycle; the active line is unchanged until then.
- Code 0: with the macro -> out_line=0x01 for HOLD cycles. Without the macro -> out_line=0x00 with out_valid=1 for HOLD cycles.
- HOLD=1, SEL_W=4: stream codes 1,2,15 on consecutive cycles -> out_line=0x0002,0x0004,0x8000 on consecutive cycles; out_last constantly 1; rst pulsed during the 0x0004 cycle -> all outputs 0 at once.
